// File: rtl/sys_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_ctrl_pkg
// Description : Shared definitions for the system-control command path.
//               Holds the command FSM state encoding, the frame opcodes
//               and the default read-data timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_ctrl_pkg;

    // Command front-end FSM states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_ADDR   = 3'd1,
        WR_DATA_S = 3'd2,
        RD_ADDR   = 3'd3,
        RD_WAIT   = 3'd4,
        TX_SEND   = 3'd5
    } state_t;

    // Frame opcodes
    localparam logic [7:0] c_WR_CMD = 8'hAA;  // opcode, address, data
    localparam logic [7:0] c_RD_CMD = 8'hBB;  // opcode, address

    // Cycles to wait for register-file read data before flagging an error
    localparam int c_RD_TIMEOUT = 4;

endpackage
`default_nettype wire

// File: rtl/rf_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rf_cmd_ctrl
// Description : Command front-end between the RX deserializer, the register
//               file and the TX serializer. Decodes framed write (AA,addr,
//               data) and read (BB,addr) commands, issues single-cycle
//               register-file strobes, and forwards read data to the
//               transmitter with a valid/busy handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK              in   clock, all logic on rising edge
//   RST              in   synchronous active-high reset
//   RX_P_DATA        in   received byte
//   RX_D_VLD         in   one-cycle pulse per received byte
//   RF_RD_DATA       in   register-file read data
//   RF_RD_DATA_VALID in   register-file read-data valid
//   TX_BUSY          in   transmitter busy
//   WR_EN            out  register-file write strobe
//   RD_EN            out  register-file read strobe
//   ADDRESS          out  register-file address (held between commands)
//   WR_DATA          out  register-file write data (held between commands)
//   TX_P_DATA        out  byte to transmit
//   TX_D_VLD         out  one-cycle transmit request
//   CMD_ERR          out  one-cycle error pulse
// ============================================================================
module rf_cmd_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    ADDRESS_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD        = c_WR_CMD,
    parameter logic [DATA_WIDTH-1:0] RD_CMD        = c_RD_CMD,
    parameter int                    RD_TIMEOUT    = c_RD_TIMEOUT
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
    input  logic                     RF_RD_DATA_VALID,
    input  logic                     TX_BUSY,
    output logic                     WR_EN,
    output logic                     RD_EN,
    output logic [ADDRESS_WIDTH-1:0] ADDRESS,
    output logic [DATA_WIDTH-1:0]    WR_DATA,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    output logic                     CMD_ERR
);

    localparam int c_CNT_W = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(RD_TIMEOUT);

    state_t                   r_state,     w_state_nxt;
    logic [c_CNT_W-1:0]       r_cnt,       w_cnt_nxt;
    logic [DATA_WIDTH-1:0]    r_tx_buf,    w_tx_buf_nxt;
    logic                     r_wr_en,     w_wr_en;
    logic                     r_rd_en,     w_rd_en;
    logic [ADDRESS_WIDTH-1:0] r_address,   w_address;
    logic [DATA_WIDTH-1:0]    r_wr_data,   w_wr_data;
    logic [DATA_WIDTH-1:0]    r_tx_p_data, w_tx_p_data;
    logic                     r_tx_d_vld,  w_tx_d_vld;
    logic                     r_cmd_err,   w_cmd_err;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_tx_buf_nxt = r_tx_buf;
        w_wr_en      = 1'b0;
        w_rd_en      = 1'b0;
        w_address    = r_address;
        w_wr_data    = r_wr_data;
        w_tx_p_data  = r_tx_p_data;
        w_tx_d_vld   = 1'b0;
        w_cmd_err    = 1'b0;

        case (r_state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD) begin
                        w_state_nxt = WR_ADDR;
                    end else if (RX_P_DATA == RD_CMD) begin
                        w_state_nxt = RD_ADDR;
                    end else begin
                        w_cmd_err = 1'b1;
                    end
                end
            end

            WR_ADDR: begin
                if (RX_D_VLD) begin
                    // Upper address bits of the byte are ignored
                    w_address   = RX_P_DATA[ADDRESS_WIDTH-1:0];
                    w_state_nxt = WR_DATA_S;
                end
            end

            WR_DATA_S: begin
                if (RX_D_VLD) begin
                    w_wr_data   = RX_P_DATA;
                    w_wr_en     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end

            RD_ADDR: begin
                if (RX_D_VLD) begin
                    w_address   = RX_P_DATA[ADDRESS_WIDTH-1:0];
                    w_rd_en     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RD_WAIT;
                end
            end

            RD_WAIT: begin
                // Bytes arriving while a read is outstanding are dropped
                w_cmd_err = RX_D_VLD;
                if (RF_RD_DATA_VALID) begin
                    w_tx_buf_nxt = RF_RD_DATA;
                    // Transmitter already free: hand the byte over directly so
                    // TX_D_VLD lands one cycle after the read data.
                    if (!TX_BUSY) begin
                        w_tx_p_data = RF_RD_DATA;
                        w_tx_d_vld  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = TX_SEND;
                    end
                end else if (r_cnt == c_CNT_MAX) begin
                    w_cmd_err   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    // Only counts below the limit, so it can never wrap
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end

            TX_SEND: begin
                w_cmd_err = RX_D_VLD;
                if (!TX_BUSY) begin
                    w_tx_p_data = r_tx_buf;
                    w_tx_d_vld  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_tx_buf    <= '0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_address   <= '0;
            r_wr_data   <= '0;
            r_tx_p_data <= '0;
            r_tx_d_vld  <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tx_buf    <= w_tx_buf_nxt;
            r_wr_en     <= w_wr_en;
            r_rd_en     <= w_rd_en;
            r_address   <= w_address;
            r_wr_data   <= w_wr_data;
            r_tx_p_data <= w_tx_p_data;
            r_tx_d_vld  <= w_tx_d_vld;
            r_cmd_err   <= w_cmd_err;
        end
    end

    assign WR_EN     = r_wr_en;
    assign RD_EN     = r_rd_en;
    assign ADDRESS   = r_address;
    assign WR_DATA   = r_wr_data;
    assign TX_P_DATA = r_tx_p_data;
    assign TX_D_VLD  = r_tx_d_vld;
    assign CMD_ERR   = r_cmd_err;

endmodule
`default_nettype wire
